mmio_interval_timer: RTL and testbench
======================================

Name: mmio_interval_timer

Overview:
- Memory-mapped 16-bit down-counting interval timer on the CPU data bus, beside the LED register (0x100) and switch port (0x140).
- Decodes the CPU's mem_cmd/mem_addr. Top level gates read_data onto the shared read bus through a 16-bit tri-state buffer enabled by rd_enable.
- Gives software a periodic or one-shot timebase plus an expiry flag and interrupt line.

Parameters:
- BASE_ADDR, 9'h180, word address of register 0. Must be 4-aligned and must not overlap 0x100 or 0x140.
- PRESCALE, 1, clk cycles per counter tick; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- mem_cmd  input  2  bus command: 00 none, 01 read, 10 write.
- mem_addr  input  9  bus word address.
- write_data  input  16  CPU write data.
- read_data  output  16  register read data, combinational.
- rd_enable  output  1  high when this block owns the read bus, combinational.
- irq  output  1  expiry interrupt, level.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL, R/W: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); bits 15:3 read 0.
  - 1 LOAD, R/W: writing also copies the value into COUNT in the same edge.
  - 2 COUNT, R/W: current count.
  - 3 STATUS: bit0 EXP, write-1-to-clear; other bits read 0 (see optional feature).
- Decode: hit = mem_addr in [BASE_ADDR, BASE_ADDR+3]. Any address outside that range is ignored entirely.
- Reads:
  - rd_enable = (mem_cmd==01) & hit, combinational.
  - read_data = addressed register when rd_enable=1, else 16'h0000.
  - Zero-cycle latency; reads have no side effects.
- Writes: take effect on the rising clk edge when mem_cmd==10 & hit.
- Prescaler: pre_cnt counts 0..PRESCALE-1 only while EN=1. tick = EN & (pre_cnt==PRESCALE-1), and pre_cnt wraps to 0 on tick. A CTRL write that changes EN from 0 to 1 clears pre_cnt.
- Counter action on tick:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0: EXP <= 1. Then if AUTO=1, COUNT <= LOAD; else EN <= 0 and COUNT stays 0.
  - Period in auto mode = (LOAD+1)*PRESCALE cycles.
- irq = EXP & IE, derived from registered state only (no bus-input path).
- Collision rules (same edge):
  - CPU write to COUNT or LOAD beats tick decrement/reload.
  - CPU write to CTRL beats the one-shot EN clear.
  - An EXP set by tick beats a W1C clear.
- LOAD=0 in auto mode: EXP sets every PRESCALE cycles.
- Reset (reset=0, asynchronous, mid-operation included):
  - CTRL, LOAD, COUNT, EXP and pre_cnt all go to 0 immediately; irq=0.
  - rd_enable and read_data follow the bus inputs combinationally.
  - No writes are accepted while reset=0.

Optional Feature:
- Macro: MMIO_TIMER_OVERRUN_EN.
- Defined: STATUS bit1 OVR sets when a tick-driven expiry occurs while EXP is already 1. OVR is W1C with the same set-beats-clear rule and resets to 0.
- Undefined: STATUS bit1 reads 0, no OVR flop exists, and writes to bit1 are ignored.

Test Plan:
- Reset: run the timer, drop reset between clock edges.
  - Required: COUNT/CTRL/STATUS read 0 at once and irq=0.
  - After reset releases, a read at 0x182 returns 0x0000.
- Auto mode, PRESCALE=1: write LOAD(0x181)=3, then CTRL(0x180)=0x0007.
  - Required: COUNT reads 3,2,1,0 on successive cycles, then 3 again.
  - EXP=1 and irq=1 from the reload cycle onward; period is 4 cycles.
- One-shot: LOAD=2, CTRL=0x0001.
  - Required: COUNT reads 2,1,0; then EXP=1 and CTRL reads 0x0000. COUNT holds 0 for 10 more cycles.
  - irq stays 0 because IE=0.
- Collisions:
  - W1C 0x0001 to 0x183 on the same edge EXP sets → STATUS reads 0x0001.
  - Write COUNT=0x0010 on a tick edge → next read is 0x0010.
- Decode:
  - Read 0x140 → rd_enable=0, read_data=0x0000.
  - Read 0x183 → rd_enable=1 with STATUS.
  - Write 0x184 → no register changes.
- PRESCALE=4 build: LOAD=1, CTRL=0x0003.
  - Required: EXP sets 8 cycles after enable, and each COUNT value holds for 4 cycles.
  - With MMIO_TIMER_OVERRUN_EN defined, a second expiry without a clear reads STATUS=0x0003.

Source files
------------

// File: rtl/mmio_interval_timer.sv
// Memory-mapped 16-bit down-counting interval timer with prescaler, auto-reload and expiry interrupt.
// Optional build macro MMIO_TIMER_OVERRUN_EN adds the STATUS.OVR overrun flag (bit 1).
module mmio_interval_timer #(
    parameter logic [8:0]  BASE_ADDR = 9'h180,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        rd_enable,
    output logic        irq
);

    localparam logic [1:0]  CMD_READ    = 2'b01;
    localparam logic [1:0]  CMD_WRITE   = 2'b10;
    localparam logic [1:0]  OFF_CTRL    = 2'd0;
    localparam logic [1:0]  OFF_LOAD    = 2'd1;
    localparam logic [1:0]  OFF_COUNT   = 2'd2;
    localparam logic [1:0]  OFF_STATUS  = 2'd3;
    localparam logic [15:0] PRE_LAST    = 16'(PRESCALE - 1);

    // Address decode: the block is 4-aligned, so the upper address bits identify it.
    logic       hit;
    logic [1:0] offset;
    logic       wr_hit;
    logic       wr_ctrl;
    logic       wr_load;
    logic       wr_count;
    logic       wr_status;

    assign hit       = (mem_addr[8:2] == BASE_ADDR[8:2]);
    assign offset    = mem_addr[1:0];
    assign wr_hit    = (mem_cmd == CMD_WRITE) && hit;
    assign wr_ctrl   = wr_hit && (offset == OFF_CTRL);
    assign wr_load   = wr_hit && (offset == OFF_LOAD);
    assign wr_count  = wr_hit && (offset == OFF_COUNT);
    assign wr_status = wr_hit && (offset == OFF_STATUS);

    logic        en_reg,    en_next;
    logic        auto_reg,  auto_next;
    logic        ie_reg,    ie_next;
    logic [15:0] load_reg,  load_next;
    logic [15:0] count_reg, count_next;
    logic        exp_reg,   exp_next;
    logic [15:0] pre_cnt_reg, pre_cnt_next;

    logic tick;
    logic expire;

    assign tick   = en_reg && (pre_cnt_reg == PRE_LAST);
    assign expire = tick && (count_reg == 16'h0000);

    always_comb begin
        en_next      = en_reg;
        auto_next    = auto_reg;
        ie_next      = ie_reg;
        load_next    = load_reg;
        count_next   = count_reg;
        exp_next     = exp_reg;
        pre_cnt_next = pre_cnt_reg;

        // A CTRL write overrides the one-shot self-disable on the same edge.
        if (wr_ctrl) begin
            en_next   = write_data[0];
            auto_next = write_data[1];
            ie_next   = write_data[2];
        end else if (expire && !auto_reg) begin
            en_next = 1'b0;
        end

        if (wr_ctrl && write_data[0] && !en_reg) begin
            pre_cnt_next = 16'h0000;
        end else if (tick) begin
            pre_cnt_next = 16'h0000;
        end else if (en_reg) begin
            pre_cnt_next = pre_cnt_reg + 16'h0001;
        end

        if (wr_load) begin
            load_next = write_data;
        end

        // Software writes to LOAD/COUNT win over the tick's decrement or reload.
        if (wr_load || wr_count) begin
            count_next = write_data;
        end else if (tick) begin
            if (count_reg != 16'h0000) begin
                count_next = count_reg - 16'h0001;
            end else if (auto_reg) begin
                count_next = load_reg;
            end
        end

        if (expire) begin
            exp_next = 1'b1;
        end else if (wr_status && write_data[0]) begin
            exp_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_reg      <= 1'b0;
            auto_reg    <= 1'b0;
            ie_reg      <= 1'b0;
            load_reg    <= 16'h0000;
            count_reg   <= 16'h0000;
            exp_reg     <= 1'b0;
            pre_cnt_reg <= 16'h0000;
        end else begin
            en_reg      <= en_next;
            auto_reg    <= auto_next;
            ie_reg      <= ie_next;
            load_reg    <= load_next;
            count_reg   <= count_next;
            exp_reg     <= exp_next;
            pre_cnt_reg <= pre_cnt_next;
        end
    end

    logic [15:0] status_word;

`ifdef MMIO_TIMER_OVERRUN_EN
    // Overrun: an expiry arrives while the previous one is still unacknowledged.
    logic ovr_reg, ovr_next;

    always_comb begin
        ovr_next = ovr_reg;
        if (expire && exp_reg) begin
            ovr_next = 1'b1;
        end else if (wr_status && write_data[1]) begin
            ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_reg <= 1'b0;
        end else begin
            ovr_reg <= ovr_next;
        end
    end

    assign status_word = {14'h0000, ovr_reg, exp_reg};
`else
    assign status_word = {15'h0000, exp_reg};
`endif

    assign rd_enable = (mem_cmd == CMD_READ) && hit;

    always_comb begin
        read_data = 16'h0000;
        if (rd_enable) begin
            case (offset)
                OFF_CTRL:   read_data = {13'h0000, ie_reg, auto_reg, en_reg};
                OFF_LOAD:   read_data = load_reg;
                OFF_COUNT:  read_data = count_reg;
                OFF_STATUS: read_data = status_word;
                default:    read_data = 16'h0000;
            endcase
        end
    end

    assign irq = exp_reg && ie_reg;

endmodule

// File: tb/tb_mmio_interval_timer.sv
// Self-checking bench for mmio_interval_timer: a PRESCALE=1 instance at 0x180 and a PRESCALE=4 instance at 0x1C0 on one bus.
module tb_mmio_interval_timer;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

`ifdef MMIO_TIMER_OVERRUN_EN
    localparam logic [15:0] STATUS_TWICE = 16'h0003;
`else
    localparam logic [15:0] STATUS_TWICE = 16'h0001;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_cmd = CMD_NONE;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data_a, read_data_b;
    logic        rd_enable_a, rd_enable_b;
    logic        irq_a, irq_b;

    always #5 clk = ~clk;

    mmio_interval_timer #(.BASE_ADDR(9'h180), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data_a),
        .rd_enable(rd_enable_a), .irq(irq_a)
    );

    mmio_interval_timer #(.BASE_ADDR(9'h1C0), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data_b),
        .rd_enable(rd_enable_b), .irq(irq_b)
    );

    // Non-owning instances drive zero, so OR-ing models the shared read bus.
    logic [15:0] bus_data;
    logic        bus_rden;
    logic        bus_irq;
    assign bus_data = read_data_a | read_data_b;
    assign bus_rden = rd_enable_a | rd_enable_b;
    assign bus_irq  = irq_a | irq_b;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] ed;
        logic        er;
        logic        ei;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic        rden;
        logic        irq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic [1:0] c, input logic [8:0] a, input logic [15:0] w,
                       input logic [15:0] e, input logic r, input logic i);
        vec_t v;
        v.cmd = c; v.addr = a; v.wd = w; v.ed = e; v.er = r; v.ei = i;
        vecs.push_back(v);
    endtask

    task automatic addw(input logic [8:0] a, input logic [15:0] w, input logic i);
        add(CMD_WRITE, a, w, 16'h0000, 1'b0, i);
    endtask

    task automatic addr_rd(input logic [8:0] a, input logic [15:0] e, input logic i);
        add(CMD_READ, a, 16'h0000, e, 1'b1, i);
    endtask

    task automatic push_exp(input string nm, input logic [15:0] ed, input logic er, input logic ei);
        exp_t e;
        e.name = nm; e.data = ed; e.rden = er; e.irq = ei;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (bus_data !== e.data || bus_rden !== e.rden || bus_irq !== e.irq) begin
            failures++;
            $display("FAIL %s: got read_data=%h rd_enable=%b irq=%b, required read_data=%h rd_enable=%b irq=%b",
                     e.name, bus_data, bus_rden, bus_irq, e.data, e.rden, e.irq);
        end
    endtask

    // One bus cycle: drive at the falling edge, compare 1 ns later (state of the previous rising edge).
    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] w, input string nm,
                        input logic [15:0] ed, input logic er, input logic ei);
        @(negedge clk);
        mem_cmd = c; mem_addr = a; write_data = w;
        push_exp(nm, ed, er, ei);
        #1 pop_check();
        $display("txn %s cmd=%b addr=%h wd=%h read_data=%h rd_enable=%b irq=%b",
                 nm, c, a, w, bus_data, bus_rden, bus_irq);
    endtask

    // Immediate combinational check without waiting for a clock edge.
    task automatic imm(input string nm, input logic [8:0] a, input logic [15:0] ed,
                       input logic er, input logic ei);
        mem_cmd = CMD_READ; mem_addr = a; write_data = 16'h0000;
        push_exp(nm, ed, er, ei);
        #1 pop_check();
        $display("txn %s read addr=%h read_data=%h rd_enable=%b irq=%b", nm, a, bus_data, bus_rden, bus_irq);
    endtask

    initial begin
        // Auto mode, PRESCALE=1, LOAD=3, IE on.
        addw(9'h181, 16'h0003, 1'b0);
        addw(9'h180, 16'h0007, 1'b0);
        addr_rd(9'h182, 16'd3, 1'b0);
        addr_rd(9'h182, 16'd2, 1'b0);
        addr_rd(9'h182, 16'd1, 1'b0);
        addr_rd(9'h182, 16'd0, 1'b0);
        addr_rd(9'h182, 16'd3, 1'b1);
        addr_rd(9'h182, 16'd2, 1'b1);
        addr_rd(9'h183, 16'h0001, 1'b1);
        addr_rd(9'h182, 16'd0, 1'b1);
        addr_rd(9'h182, 16'd3, 1'b1);
        // Clear flags, then W1C exactly on an expiry edge: the set wins.
        addw(9'h183, 16'h0003, 1'b1);
        addr_rd(9'h183, 16'h0000, 1'b0);
        addw(9'h183, 16'h0001, 1'b0);
        addr_rd(9'h183, 16'h0001, 1'b1);
        // Decode: neighbours are not ours.
        add(CMD_READ, 9'h140, 16'h0000, 16'h0000, 1'b0, 1'b1);
        add(CMD_READ, 9'h100, 16'h0000, 16'h0000, 1'b0, 1'b1);
        // COUNT write on a reload edge wins.
        addw(9'h182, 16'h0010, 1'b1);
        addr_rd(9'h182, 16'h0010, 1'b1);
        addr_rd(9'h182, 16'h000F, 1'b1);
        addw(9'h184, 16'h1234, 1'b1);
        addr_rd(9'h182, 16'h000D, 1'b1);
        addr_rd(9'h181, 16'h0003, 1'b1);
        addr_rd(9'h180, 16'h0007, 1'b1);
        // One-shot, LOAD=2, IE off.
        addw(9'h180, 16'h0000, 1'b1);
        addw(9'h183, 16'h0003, 1'b0);
        addw(9'h181, 16'h0002, 1'b0);
        addw(9'h180, 16'h0001, 1'b0);
        addr_rd(9'h182, 16'd2, 1'b0);
        addr_rd(9'h182, 16'd1, 1'b0);
        addr_rd(9'h182, 16'd0, 1'b0);
        addr_rd(9'h183, 16'h0001, 1'b0);
        addr_rd(9'h180, 16'h0000, 1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        imm("rst_ctrl",   9'h180, 16'h0000, 1'b1, 1'b0);
        imm("rst_load",   9'h181, 16'h0000, 1'b1, 1'b0);
        imm("rst_count",  9'h182, 16'h0000, 1'b1, 1'b0);
        imm("rst_status", 9'h183, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cmd, vecs[i].addr, vecs[i].wd, $sformatf("row%0d", i),
                 vecs[i].ed, vecs[i].er, vecs[i].ei);
        end
        for (int i = 0; i < 10; i++) begin
            step(CMD_READ, 9'h182, 16'h0000, $sformatf("oneshot_hold%0d", i), 16'h0000, 1'b1, 1'b0);
        end

        // Mid-operation asynchronous reset with irq asserted.
        step(CMD_WRITE, 9'h183, 16'h0003, "pre_rst_clr",  16'h0000, 1'b0, 1'b0);
        step(CMD_WRITE, 9'h181, 16'h0001, "pre_rst_load", 16'h0000, 1'b0, 1'b0);
        step(CMD_WRITE, 9'h180, 16'h0007, "pre_rst_ctrl", 16'h0000, 1'b0, 1'b0);
        step(CMD_READ,  9'h182, 16'h0000, "pre_rst_c1",   16'h0001, 1'b1, 1'b0);
        step(CMD_READ,  9'h182, 16'h0000, "pre_rst_c0",   16'h0000, 1'b1, 1'b0);
        step(CMD_READ,  9'h183, 16'h0000, "pre_rst_exp",  16'h0001, 1'b1, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        imm("async_count",  9'h182, 16'h0000, 1'b1, 1'b0);
        imm("async_ctrl",   9'h180, 16'h0000, 1'b1, 1'b0);
        imm("async_status", 9'h183, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        mem_cmd = CMD_WRITE; mem_addr = 9'h180; write_data = 16'h0007;
        @(negedge clk);
        imm("write_in_reset", 9'h180, 16'h0000, 1'b1, 1'b0);
        mem_cmd = CMD_NONE;
        reset = 1'b1;
        step(CMD_READ, 9'h182, 16'h0000, "post_rst_count", 16'h0000, 1'b1, 1'b0);

        // PRESCALE=4 instance: LOAD=1, auto, no IE.
        step(CMD_WRITE, 9'h1C1, 16'h0001, "p4_load", 16'h0000, 1'b0, 1'b0);
        step(CMD_WRITE, 9'h1C0, 16'h0003, "p4_ctrl", 16'h0000, 1'b0, 1'b0);
        for (int r = 0; r <= 16; r++) begin
            if (r == 7) begin
                step(CMD_READ, 9'h1C3, 16'h0000, "p4_status_pre", 16'h0000, 1'b1, 1'b0);
            end else if (r == 8) begin
                step(CMD_READ, 9'h1C3, 16'h0000, "p4_status_exp", 16'h0001, 1'b1, 1'b0);
            end else if (r == 16) begin
                step(CMD_READ, 9'h1C3, 16'h0000, "p4_status_twice", STATUS_TWICE, 1'b1, 1'b0);
            end else begin
                step(CMD_READ, 9'h1C2, 16'h0000, $sformatf("p4_count%0d", r),
                     ((r % 8) < 4) ? 16'h0001 : 16'h0000, 1'b1, 1'b0);
            end
        end

        @(negedge clk);
        mem_cmd = CMD_NONE;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
